// File: rtl/ex_md_stage_pkg.sv
// ex_md_stage_pkg: shared op codes, widths, MD FSM states and MD op-class decode
package ex_md_stage_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_OPW = 5;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_SLL = 5'd5;
  localparam logic [4:0] OP_SRL = 5'd6;
  localparam logic [4:0] OP_SRA = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_MUL = 5'd16;
  localparam logic [4:0] OP_MULH = 5'd17;
  localparam logic [4:0] OP_MULHU = 5'd18;
  localparam logic [4:0] OP_DIV = 5'd20;
  localparam logic [4:0] OP_DIVU = 5'd21;
  localparam logic [4:0] OP_REM = 5'd22;
  localparam logic [4:0] OP_REMU = 5'd23;
  typedef enum logic {IDLE, RUN} md_state_e;
  function automatic logic is_md(input logic [DEF_OPW-1:0] op);
    return op == OP_MUL || op == OP_MULH || op == OP_MULHU || (op >= OP_DIV && op <= OP_REMU);
  endfunction
endpackage

// File: rtl/ex_md_stage_md_iter_unit.sv
// md_iter_unit: 1-bit/cycle shift-add multiplier and restoring divider on magnitudes
module md_iter_unit
  import ex_md_stage_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int OPW = DEF_OPW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  md_state_e state;
  logic [CW-1:0] cnt;
  logic [OPW-1:0] op_q;
  logic [XLEN-1:0] hi, lo, mag, a_q, hi_n, lo_n, ma, mb, q, r;
  logic neg, dz, sa, sb, dv, div_q, sgn;
  logic [XLEN:0] sum, sh, diff;
  logic [2*XLEN-1:0] prod;
  assign dv = op[2];
  assign sgn = op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM;
  assign sa = sgn && a[XLEN-1];
  assign sb = sgn && b[XLEN-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign div_q = op_q[2];
  // hi/lo hold {product hi, multiplier} when multiplying, {remainder, quotient} when dividing
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, mag} : '0);
  assign sh = {hi, lo[XLEN-1]};
  assign diff = sh - {1'b0, mag};
  assign hi_n = div_q ? (diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
  assign lo_n = div_q ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
  assign prod = neg ? -{hi_n, lo_n} : {hi_n, lo_n};
  assign q = neg ? -lo_n : lo_n;
  assign r = neg ? -hi_n : hi_n;
  assign result = op_q == OP_MUL ? prod[XLEN-1:0] :
                  !div_q ? prod[2*XLEN-1:XLEN] :
                  op_q[1] ? (dz ? a_q : r) : (dz ? '1 : q);
  assign busy = state == RUN;
  assign done = busy && cnt == CW'(XLEN - 1);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      hi <= '0;
      lo <= '0;
      mag <= '0;
      a_q <= '0;
      neg <= 1'b0;
      dz <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        cnt <= '0;
        op_q <= op;
        hi <= '0;
        lo <= dv ? ma : mb;
        mag <= dv ? mb : ma;
        a_q <= a;
        neg <= op == OP_REM ? sa : sa ^ sb;
        dz <= dv && b == '0;
      end
    end else begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + 1'b1;
      if (done) state <= IDLE;
    end
  end
endmodule

// File: rtl/ex_md_stage.sv
// ex_md_stage: execute stage (ALU + iterative RV32M engine) with EX/MEM pipeline latch
module ex_md_stage
  import ex_md_stage_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int OPW = DEF_OPW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [XLEN-1:0] rdata2,
  input  logic [1:0]      wb_ctl,
  input  logic [2:0]      m_ctl,
  input  logic [4:0]      write_reg,
  input  logic            flush,
  output logic            stall_out,
  output logic            ex_valid,
  output logic [1:0]      wb_ctlout,
  output logic            branch,
  output logic            memread,
  output logic            memwrite,
  output logic            zero,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] rdata2out,
  output logic [4:0]      five_bit_muxout
);
  logic md, busy, done, go, start;
  logic [4:0] sh;
  logic [XLEN-1:0] alu, md_res, res, h_rd2;
  logic [1:0] h_wb;
  logic [2:0] h_m;
  logic [4:0] h_wr;
  assign md = is_md(alu_op);
  assign go = !busy && id_valid && !md;
  assign start = !busy && id_valid && md && !flush;
  assign stall_out = (!busy && id_valid && md) || (busy && !done);
  assign sh = operand_b[4:0];
  assign res = done ? md_res : alu;
  always_comb begin
    alu = '0;
    case (alu_op)
      OP_ADD:  alu = operand_a + operand_b;
      OP_SUB:  alu = operand_a - operand_b;
      OP_AND:  alu = operand_a & operand_b;
      OP_OR:   alu = operand_a | operand_b;
      OP_XOR:  alu = operand_a ^ operand_b;
      OP_SLL:  alu = operand_a << sh;
      OP_SRL:  alu = operand_a >> sh;
      OP_SRA:  alu = $signed(operand_a) >>> sh;
      OP_SLT:  alu = XLEN'($signed(operand_a) < $signed(operand_b));
      OP_SLTU: alu = XLEN'(operand_a < operand_b);
      default: alu = '0;
    endcase
  end
  md_iter_unit #(.XLEN(XLEN), .OPW(OPW)) u_md (
    .clock(clock), .reset(reset), .start(start), .flush(flush), .op(alu_op),
    .a(operand_a), .b(operand_b), .busy(busy), .done(done), .result(md_res)
  );
  // controls of the MD instruction are parked here while upstream moves on at the final edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_wb <= '0;
      h_m <= '0;
      h_wr <= '0;
      h_rd2 <= '0;
    end else if (start) begin
      h_wb <= wb_ctl;
      h_m <= m_ctl;
      h_wr <= write_reg;
      h_rd2 <= rdata2;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      wb_ctlout <= '0;
      {branch, memread, memwrite} <= 3'b0;
      zero <= 1'b0;
      alu_result <= '0;
      rdata2out <= '0;
      five_bit_muxout <= '0;
    end else if (flush || !(done || go)) begin
      ex_valid <= 1'b0;
      wb_ctlout <= '0;
      {branch, memread, memwrite} <= 3'b0;
    end else begin
      ex_valid <= 1'b1;
      wb_ctlout <= done ? h_wb : wb_ctl;
      {branch, memread, memwrite} <= done ? h_m : m_ctl;
      alu_result <= res;
      zero <= res == '0;
      rdata2out <= done ? h_rd2 : rdata2;
      five_bit_muxout <= done ? h_wr : write_reg;
    end
  end
endmodule

// File: tb/tb_ex_md_stage.sv
// tb_ex_md_stage: scoreboard bench with a 64-bit arithmetic reference model
module tb_ex_md_stage;
  logic clock = 0, reset = 0, id_valid = 0, flush = 0;
  logic [4:0] alu_op = 0, write_reg = 0;
  logic [31:0] operand_a = 0, operand_b = 0, rdata2 = 0;
  logic [1:0] wb_ctl = 0;
  logic [2:0] m_ctl = 0;
  logic stall_out, ex_valid, branch, memread, memwrite, zero;
  logic [1:0] wb_ctlout;
  logic [31:0] alu_result, rdata2out;
  logic [4:0] five_bit_muxout;
  typedef struct {
    logic [31:0] res;
    logic [31:0] rd2;
    logic [1:0] wb;
    logic [2:0] m;
    logic [4:0] wr;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0, failures = 0;

  ex_md_stage dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b), .rdata2(rdata2), .wb_ctl(wb_ctl),
    .m_ctl(m_ctl), .write_reg(write_reg), .flush(flush), .stall_out(stall_out),
    .ex_valid(ex_valid), .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread),
    .memwrite(memwrite), .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .five_bit_muxout(five_bit_muxout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit ref_is_md(input logic [4:0] op);
    return op inside {5'd16, 5'd17, 5'd18, 5'd20, 5'd21, 5'd22, 5'd23};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint sp;
    logic [63:0] up, spu;
    bit ovf;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    spu = sp;
    up = {32'b0, a} * {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << b[4:0];
      6: return a >> b[4:0];
      7: return sa >>> b[4:0];
      8: return (sa < sb) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      16: return spu[31:0];
      17: return spu[63:32];
      18: return up[63:32];
      20: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : sa / sb;
      21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      22: return (b == 0) ? a : ovf ? 32'd0 : sa % sb;
      23: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] rd2, input logic [1:0] wb, input logic [2:0] m,
                       input logic [4:0] wr);
    int st = 0;
    bit ok = 0;
    id_valid = 1;
    alu_op = op;
    operand_a = a;
    operand_b = b;
    rdata2 = rd2;
    wb_ctl = wb;
    m_ctl = m;
    write_reg = wr;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!stall_out) begin
        ok = 1;
        break;
      end
      st++;
    end
    if (!ok) begin
      failures++;
      $display("FAIL stall_timeout op=%0d", op);
    end
    chk("stall_cycles", st, ref_is_md(op) ? 32 : 0);
    sb_q.push_back('{ref_alu(op, a, b), rd2, wb, m, wr});
    @(posedge clock);
    #1;
    id_valid = 0;
    chk("retire_latency", ex_valid, 1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clock) begin
    if (reset && ex_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_retire actual=%h required=none", alu_result);
      end else begin
        mon_e = sb_q.pop_front();
        chk("alu_result", alu_result, mon_e.res);
        chk("zero", zero, mon_e.res == 0);
        chk("wb_ctlout", wb_ctlout, mon_e.wb);
        chk("m_ctl_out", {branch, memread, memwrite}, mon_e.m);
        chk("rdata2out", rdata2out, mon_e.rd2);
        chk("five_bit_muxout", five_bit_muxout, mon_e.wr);
      end
    end else if (reset) begin
      chk("bubble_ctl", {wb_ctlout, branch, memread, memwrite}, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ops [18];
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
            5'd12, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd22, 5'd23};
    #12;
    chk("reset_state", {stall_out, ex_valid, wb_ctlout, branch, memread, memwrite, zero,
                        alu_result, five_bit_muxout}, 0);
    chk("reset_rdata2out", rdata2out, 0);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    issue(5'd0, 5, 7, 32'h11, 2'b10, 3'b000, 5'd3);
    issue(5'd1, 9, 9, 32'h22, 2'b00, 3'b100, 5'd0);
    issue(5'd16, 32'hFFFF_FFFF, 2, 0, 2'b10, 3'b000, 5'd4);
    issue(5'd17, 32'h8000_0000, 32'h8000_0000, 0, 2'b10, 3'b000, 5'd5);
    issue(5'd20, 7, 0, 0, 2'b10, 3'b000, 5'd6);
    issue(5'd22, 7, 0, 0, 2'b10, 3'b000, 5'd7);
    issue(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'b10, 3'b000, 5'd8);
    issue(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2'b10, 3'b000, 5'd9);
    issue(5'd21, 100, 7, 32'h33, 2'b11, 3'b001, 5'd10);
    issue(5'd23, 100, 7, 0, 2'b10, 3'b000, 5'd11);
    // abort a DIV partway through RUN
    id_valid = 1;
    alu_op = 5'd20;
    operand_a = 1000;
    operand_b = 3;
    @(posedge clock);
    repeat (10) @(posedge clock);
    #1;
    flush = 1;
    id_valid = 0;
    #1;
    chk("flush_stall_from_state", stall_out, 1);
    @(posedge clock);
    #1;
    flush = 0;
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_stall_idle", stall_out, 0);
    issue(5'd0, 20, 22, 0, 2'b10, 3'b000, 5'd12);
    // a new op arriving with flush is dropped
    id_valid = 1;
    alu_op = 5'd0;
    operand_a = 1;
    operand_b = 2;
    flush = 1;
    @(posedge clock);
    #1;
    chk("flush_drop_single", ex_valid, 0);
    alu_op = 5'd16;
    @(posedge clock);
    #1;
    flush = 0;
    id_valid = 0;
    #1;
    chk("flush_drop_md", stall_out, 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      issue(ops[$urandom_range(0, 17)], pick_val(), pick_val(), $urandom,
            2'($urandom), 3'($urandom), 5'($urandom));
    end
    issue(5'd0, 3, 4, 0, 2'b10, 3'b000, 5'd13);
    // asynchronous reset in the middle of a multiply
    id_valid = 1;
    alu_op = 5'd16;
    operand_a = 3;
    operand_b = 5;
    @(posedge clock);
    repeat (5) @(posedge clock);
    #2;
    reset = 0;
    id_valid = 0;
    #1;
    chk("async_reset", {stall_out, ex_valid, wb_ctlout, branch, memread, memwrite, zero,
                        alu_result, five_bit_muxout}, 0);
    chk("async_reset_rdata2out", rdata2out, 0);
    #3;
    reset = 1;
    @(posedge clock);
    #1;
    issue(5'd0, 1, 1, 0, 2'b10, 3'b000, 5'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
